// File: rtl/ws281x_recv.sv
// WS281x NRZ receiver: measures each high pulse, decodes bits MSB-first into
// 24-bit pixels and streams them into the transmit path's 64x32 pixel RAM.
module ws281x_recv #(
    parameter int CNT_WIDTH  = 16,
    parameter int RST_CYCLES = 10000,
    parameter int MIN_HIGH   = 2,
    parameter int MAX_HIGH   = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        ws281x_in,
    input  logic [7:0]  tim_bit_in,
    output logic        wr_en_out,
    output logic [5:0]  wr_addr_out,
    output logic [31:0] wr_data_out,
    output logic        frame_done_out,
    output logic [6:0]  word_cnt_out,
    output logic        err_out
);

    typedef enum logic [1:0] {
        WAIT_LATCH = 2'd0,
        LOW        = 2'd1,
        HIGH       = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_H    = CNT_WIDTH'(MIN_HIGH);
    localparam logic [CNT_WIDTH-1:0] MAX_H    = CNT_WIDTH'(MAX_HIGH);
    localparam logic [6:0]           WORDS    = 7'd64;
    localparam logic [4:0]           LAST_BIT = 5'd23;

    state_t               state;
    state_t               next_state;
    logic                 sync_q1;
    logic                 sync_q2;
    logic                 sync_q3;
    logic                 level;
    logic                 rise;
    logic                 fall;
    logic [CNT_WIDTH-1:0] low_cnt;
    logic [CNT_WIDTH-1:0] high_cnt;
    logic [CNT_WIDTH-1:0] low_inc;
    logic [CNT_WIDTH-1:0] high_inc;
    logic [23:0]          shreg;
    logic [4:0]           bit_cnt;
    logic [6:0]           wcnt;
    logic                 got_bit;
    logic                 word_pend;
    logic                 bit_val;
    logic                 latch_seen;
    logic                 too_long;
    logic                 glitch;
    logic                 bit_valid;
    logic                 frame_end;

    // Two flops resynchronise the pin; the third gives the previous level for edges.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            sync_q3 <= 1'b0;
        end else begin
            sync_q1 <= ws281x_in;
            sync_q2 <= sync_q1;
            sync_q3 <= sync_q2;
        end
    end

    assign level    = sync_q2;
    assign rise     = sync_q2 & ~sync_q3;
    assign fall     = ~sync_q2 & sync_q3;
    assign low_inc  = (low_cnt == CNT_SAT) ? low_cnt : low_cnt + CNT_ONE;
    assign high_inc = (high_cnt == CNT_SAT) ? high_cnt : high_cnt + CNT_ONE;
    assign bit_val  = (high_cnt >= CNT_WIDTH'(tim_bit_in));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= WAIT_LATCH;
        else           state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        latch_seen = 1'b0;
        too_long   = 1'b0;
        glitch     = 1'b0;
        bit_valid  = 1'b0;
        frame_end  = 1'b0;
        case (state)
            WAIT_LATCH: begin
                if (!level && low_cnt == RST_LAST) begin
                    next_state = LOW;
                    latch_seen = 1'b1;
                end
            end
            LOW: begin
                if (rise) begin
                    next_state = HIGH;
                end else if (!level && low_cnt == RST_LAST) begin
                    frame_end = 1'b1;
                end
            end
            HIGH: begin
                if (high_cnt > MAX_H) begin
                    too_long   = 1'b1;
                    next_state = WAIT_LATCH;
                end else if (fall) begin
                    next_state = LOW;
                    if (high_cnt < MIN_H) glitch    = 1'b1;
                    else                  bit_valid = 1'b1;
                end
            end
            default: next_state = WAIT_LATCH;
        endcase
    end

    // Counters include the edge sample itself, so they hold exact pulse widths.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            low_cnt  <= '0;
            high_cnt <= '0;
        end else begin
            case (state)
                WAIT_LATCH: low_cnt <= level ? '0 : low_inc;
                LOW: begin
                    if (rise) high_cnt <= CNT_ONE;
                    else      low_cnt  <= low_inc;
                end
                HIGH: begin
                    if (too_long)       low_cnt <= '0;
                    else if (glitch)    low_cnt <= low_inc;
                    else if (bit_valid) low_cnt <= CNT_ONE;
                    if (level) high_cnt <= high_inc;
                end
                default: low_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shreg          <= '0;
            bit_cnt        <= '0;
            wcnt           <= '0;
            got_bit        <= 1'b0;
            word_pend      <= 1'b0;
            wr_en_out      <= 1'b0;
            wr_addr_out    <= '0;
            wr_data_out    <= '0;
            frame_done_out <= 1'b0;
            word_cnt_out   <= '0;
            err_out        <= 1'b0;
        end else begin
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;

            // Leaving the start-up/error wait always begins a clean frame.
            if (latch_seen) begin
                bit_cnt     <= '0;
                wcnt        <= '0;
                got_bit     <= 1'b0;
                wr_addr_out <= '0;
            end

            if (too_long) begin
                err_out <= 1'b1;
                bit_cnt <= '0;
            end

            if (glitch) err_out <= 1'b1;

            if (bit_valid) begin
                shreg   <= {shreg[22:0], bit_val};
                got_bit <= 1'b1;
                if (!got_bit) err_out <= 1'b0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    word_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end

            if (word_pend) begin
                word_pend <= 1'b0;
                if (wcnt == WORDS) begin
                    err_out <= 1'b1;
                end else begin
                    wr_en_out   <= 1'b1;
                    wr_data_out <= {8'h00, shreg};
                    wcnt        <= wcnt + 7'd1;
                end
            end

            // Address advances after the strobe and parks at 63 once the RAM is full.
            if (wr_en_out && wcnt != WORDS) wr_addr_out <= wr_addr_out + 6'd1;

            if (frame_end && got_bit) begin
                frame_done_out <= 1'b1;
                word_cnt_out   <= wcnt;
                wcnt           <= '0;
                wr_addr_out    <= '0;
                got_bit        <= 1'b0;
                bit_cnt        <= '0;
                if (bit_cnt != 5'd0) err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ws281x_recv.sv
// Directed/randomised bench for ws281x_recv: the expected pixels come from the
// pulse widths the bench itself generates and the width-vs-threshold rule.
`timescale 1ns/100ps
module tb_ws281x_recv;

    localparam int RST_CYCLES = 200;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [6:0] cnt;
        logic       err;
        int         cyc;
    } fr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws = 1'b0;
    logic [7:0]  tim = 8'd8;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_done;
    logic [6:0]  word_cnt;
    logic        err;

    int          cyc = 0;
    int          last_fall = 0;
    int          tests = 0;
    int          fails = 0;
    wr_t         writes[$];
    fr_t         frames[$];
    logic [23:0] exp_q[$];

    ws281x_recv #(
        .CNT_WIDTH (16),
        .RST_CYCLES(RST_CYCLES),
        .MIN_HIGH  (2),
        .MAX_HIGH  (255)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .ws281x_in     (ws),
        .tim_bit_in    (tim),
        .wr_en_out     (wr_en),
        .wr_addr_out   (wr_addr),
        .wr_data_out   (wr_data),
        .frame_done_out(frame_done),
        .word_cnt_out  (word_cnt),
        .err_out       (err)
    );

    always #2.5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en)      writes.push_back('{wr_addr, wr_data});
        if (frame_done) frames.push_back('{word_cnt, err, cyc});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input int hw, input int lw);
        ws = 1'b1;
        repeat (hw) @(negedge clk);
        ws = 1'b0;
        last_fall = cyc;
        repeat (lw) @(negedge clk);
    endtask

    task automatic send_std_bit(input logic b);
        if (b) send_bit(12, 6);
        else   send_bit(4, 14);
    endtask

    task automatic send_std_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_std_bit(w[i]);
    endtask

    // Random widths; the expected bit follows "width >= threshold".
    task automatic send_rand_word(output logic [23:0] w);
        int hw;
        w = '0;
        for (int i = 0; i < 24; i++) begin
            hw = $urandom_range(2, 16);
            w  = {w[22:0], (hw >= int'(tim))};
            send_bit(hw, $urandom_range(6, 12));
        end
    endtask

    task automatic latch();
        ws = 1'b0;
        repeat (RST_CYCLES + 60) @(negedge clk);
    endtask

    task automatic clear_obs();
        writes.delete();
        frames.delete();
        exp_q.delete();
    endtask

    task automatic check_frame(input string tag, input logic exp_err);
        int n_exp;
        int lat;
        n_exp = (exp_q.size() > 64) ? 64 : exp_q.size();
        check({tag, " frames"}, frames.size(), 1);
        if (frames.size() > 0) begin
            lat = frames[0].cyc - last_fall;
            check({tag, " word_cnt"}, frames[0].cnt, n_exp);
            check({tag, " frame_err"}, frames[0].err, exp_err);
            check({tag, " latency_ok"}, (lat >= RST_CYCLES) && (lat <= RST_CYCLES + 6), 1);
        end
        check({tag, " writes"}, writes.size(), n_exp);
        for (int i = 0; i < writes.size() && i < n_exp; i++) begin
            check($sformatf("%s addr%0d", tag, i), writes[i].addr, i);
            check($sformatf("%s data%0d", tag, i), writes[i].data, {8'h00, exp_q[i]});
        end
    endtask

    initial begin
        logic [23:0] w;
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst wr_en", wr_en, 0);
        check("rst wr_addr", wr_addr, 0);
        check("rst wr_data", wr_data, 0);
        check("rst frame_done", frame_done, 0);
        check("rst word_cnt", word_cnt, 0);
        check("rst err", err, 0);
        rst_n = 1'b1;

        // Initial latch yields no frame pulse
        repeat (250) @(negedge clk);
        check("init no frame", frames.size(), 0);

        // Single pixel
        clear_obs();
        exp_q.push_back(24'hAACCCC);
        send_std_word(24'hAACCCC);
        latch();
        check_frame("t1", 1'b0);

        // Three words, then a one-word frame
        clear_obs();
        exp_q.push_back(24'hAAAACC);
        exp_q.push_back(24'h00AADD);
        exp_q.push_back(24'hFFFFFF);
        foreach (exp_q[i]) send_std_word(exp_q[i]);
        latch();
        check_frame("t2a", 1'b0);
        clear_obs();
        w = 24'($urandom);
        exp_q.push_back(w);
        send_std_word(w);
        latch();
        check_frame("t2b", 1'b0);

        // Random widths and thresholds
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            tim = 8'($urandom_range(5, 11));
            n   = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                send_rand_word(w);
                exp_q.push_back(w);
            end
            latch();
            check_frame($sformatf("rand%0d", f), 1'b0);
        end

        // Zero threshold: every valid pulse is a 1
        clear_obs();
        tim = 8'd0;
        send_rand_word(w);
        exp_q.push_back(w);
        latch();
        check_frame("tim0", 1'b0);
        tim = 8'd8;

        // 30 bits: one word plus a discarded partial word
        clear_obs();
        w = 24'($urandom);
        exp_q.push_back(w);
        send_std_word(w);
        for (int i = 0; i < 6; i++) send_std_bit(1'($urandom));
        latch();
        check_frame("t3", 1'b1);

        // Glitch between bits 5 and 6
        clear_obs();
        w = 24'($urandom);
        exp_q.push_back(w);
        for (int i = 23; i >= 0; i--) begin
            send_std_bit(w[i]);
            if (i == 19) begin
                ws = 1'b1;
                @(negedge clk);
                ws = 1'b0;
                repeat (6) @(negedge clk);
            end
        end
        check("t4 err after glitch", err, 1);
        latch();
        check_frame("t4", 1'b1);
        clear_obs();
        check("t4 err held", err, 1);
        w = 24'($urandom);
        exp_q.push_back(w);
        send_std_bit(w[23]);
        check("t4 err cleared", err, 0);
        for (int i = 22; i >= 0; i--) send_std_bit(w[i]);
        latch();
        check_frame("t4b", 1'b0);

        // Overflow: 65 words, 64 written
        clear_obs();
        for (int k = 0; k < 65; k++) begin
            w = 24'($urandom);
            exp_q.push_back(w);
            send_std_word(w);
        end
        latch();
        check_frame("t5", 1'b1);

        // Over-long high pulse
        clear_obs();
        ws = 1'b1;
        repeat (300) @(negedge clk);
        ws = 1'b0;
        repeat (20) @(negedge clk);
        check("long err", err, 1);
        check("long no write", writes.size(), 0);
        latch();
        send_std_word(24'h123456);
        exp_q.push_back(24'h123456);
        latch();
        check_frame("long", 1'b0);

        // Reset mid-word, then data without a preceding latch
        clear_obs();
        for (int i = 0; i < 12; i++) send_std_bit(1'($urandom));
        rst_n = 1'b0;
        @(negedge clk);
        check("t6 rst word_cnt", word_cnt, 0);
        check("t6 rst addr", wr_addr, 0);
        rst_n = 1'b1;
        send_std_word(24'($urandom));
        latch();
        check("t6 no write", writes.size(), 0);
        check("t6 no frame", frames.size(), 0);
        w = 24'($urandom);
        exp_q.push_back(w);
        send_std_word(w);
        latch();
        check_frame("t6", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
